team_06_echo_history_buffer: RTL and testbench

Sample-history controller that sits beside `team_06_echo_effect`. It stores every processed sample (`save_audio`) into an external 8192×8 SRAM ring. On a `search` request it fetches the sample written `offset` samples ago and returns it as `past_output`. It owns the write pointer, the fill level and the single-port memory arbitration; the echo stage only issues requests and consumes results.

---
 rtl/team_06_echo_history_buffer_pkg.sv | 6 +
 rtl/team_06_echo_history_buffer.sv | 113 +++++++++++
 tb/tb_team_06_echo_history_buffer.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/team_06_echo_history_buffer_pkg.sv
// team_06_pkg: shared state encoding and geometry of the echo sample-history ring.
package team_06_pkg;
    localparam int ECHO_HIST_DEPTH  = 8192;
    localparam int ECHO_HIST_ADDR_W = 13;
    typedef enum logic [1:0] {IDLE, WRITE, READ, ZERO} echo_hist_state_t;
endpackage

// File: rtl/team_06_echo_history_buffer.sv
// team_06_echo_history_buffer: owns the SRAM history ring (write pointer, pending requests, port arbitration).
// Define TEAM_06_ECHO_HIST_ZERO_FILL_EN to return 0 for reads of never-written slots.
module team_06_echo_history_buffer
    import team_06_pkg::*;
#(
    parameter int DEPTH  = ECHO_HIST_DEPTH,
    parameter int ADDR_W = ECHO_HIST_ADDR_W,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] save_audio,
    input  logic              search,
    input  logic [ADDR_W-1:0] offset,
    output logic [DATA_W-1:0] past_output,
    output logic              past_valid,
    output logic              overrun,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);
    echo_hist_state_t  r_state, w_next;
    logic              r_wr_pend, r_rd_pend, r_ovr, r_req, r_we, r_pv;
    logic [DATA_W-1:0] r_wbuf, r_wdata, r_past;
    logic [ADDR_W-1:0] r_off, r_wr_ptr, r_addr;
    logic              w_wr_pend, w_rd_pend, w_wr_done, w_rd_done, w_zero, w_req, w_pv;
    logic [DATA_W-1:0] w_wbuf;
    logic [ADDR_W-1:0] w_off, w_rd_addr;

    // Same-cycle strobes count as pending so the FSM can leave IDLE immediately.
    assign w_wr_pend = r_wr_pend | sample_valid;
    assign w_rd_pend = r_rd_pend | search;
    assign w_wbuf    = sample_valid ? save_audio : r_wbuf;
    assign w_off     = search ? offset : r_off;
    assign w_rd_addr = r_wr_ptr - w_off;
    assign w_wr_done = (r_state == WRITE) && mem_ack;
    assign w_rd_done = (r_state == READ) && mem_ack;

`ifdef TEAM_06_ECHO_HIST_ZERO_FILL_EN
    localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
    logic [ADDR_W:0] r_fill;
    assign w_zero = ({1'b0, w_off} > r_fill) || (w_off == '0 && r_fill != FULL);
    always_ff @(posedge clk or posedge rst)
        if (rst) r_fill <= '0;
        else if (w_wr_done && r_fill != FULL) r_fill <= r_fill + 1'b1;
`else
    assign w_zero = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst)
        if (rst) r_state <= IDLE;
        else r_state <= w_next;

    always_comb begin
        w_next = r_state;
        if (r_state == IDLE) w_next = w_wr_pend ? WRITE : (w_rd_pend ? (w_zero ? ZERO : READ) : IDLE);
        else if (r_state == ZERO || mem_ack) w_next = IDLE;
    end

    always_comb begin
        w_req = (w_next == WRITE) || (w_next == READ);
        w_pv  = w_rd_done || (r_state == ZERO);
    end

    // Address and data are frozen on leaving IDLE so new strobes cannot disturb a stalled access.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_pv    <= 1'b0;
            r_past  <= '0;
        end else begin
            r_req <= w_req;
            r_pv  <= w_pv;
            if (w_pv) r_past <= (r_state == READ) ? mem_rdata : '0;
            if (r_state == IDLE) begin
                r_we    <= w_next == WRITE;
                r_addr  <= (w_next == WRITE) ? r_wr_ptr : w_rd_addr;
                r_wdata <= w_wbuf;
            end
        end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_wr_pend <= 1'b0;
            r_rd_pend <= 1'b0;
            r_wbuf    <= '0;
            r_off     <= '0;
            r_wr_ptr  <= '0;
            r_ovr     <= 1'b0;
        end else begin
            r_wr_pend <= sample_valid | (r_wr_pend & ~w_wr_done);
            r_rd_pend <= search | (r_rd_pend & ~w_pv);
            if (sample_valid) r_wbuf <= save_audio;
            if (search) r_off <= offset;
            if (w_wr_done) r_wr_ptr <= ADDR_W'((int'(r_wr_ptr) + 1) % DEPTH);
            r_ovr <= r_ovr | (sample_valid & r_wr_pend & ~w_wr_done);
        end

    assign past_output = r_past;
    assign past_valid  = r_pv;
    assign overrun     = r_ovr;
    assign mem_req     = r_req;
    assign mem_we      = r_we;
    assign mem_addr    = r_addr;
    assign mem_wdata   = r_wdata;
endmodule

// File: tb/tb_team_06_echo_history_buffer.sv
// tb_team_06_echo_history_buffer: vector table, directed corner sequences and a randomized history model.
module tb_team_06_echo_history_buffer;
    localparam int DEPTH = 8192;
`ifdef TEAM_06_ECHO_HIST_ZERO_FILL_EN
    localparam bit ZF = 1'b1;
`else
    localparam bit ZF = 1'b0;
`endif

    logic        clk = 1'b0, rst = 1'b1, clr = 1'b1;
    logic        sample_valid = 1'b0, search = 1'b0;
    logic [7:0]  save_audio = '0;
    logic [12:0] offset = '0;
    logic [7:0]  past_output, mem_wdata, mem_rdata;
    logic        past_valid, overrun, mem_req, mem_we, mem_ack;
    logic [12:0] mem_addr;
    logic        ack_en = 1'b1;
    int          wait_n = 0, wcnt;
    int          checks = 0, failures = 0;

    typedef struct packed { logic we; logic [12:0] addr; logic [7:0] data; } txn_t;
    typedef struct { logic [12:0] off; logic exp_req; logic [12:0] exp_addr; logic [7:0] exp_data; } vec_t;
    txn_t       log_q[$];
    logic [7:0] mem[DEPTH];
    logic [7:0] hist[$];
    vec_t       tbl[5];

    team_06_echo_history_buffer dut (
        .clk(clk), .rst(rst), .sample_valid(sample_valid), .save_audio(save_audio),
        .search(search), .offset(offset), .past_output(past_output), .past_valid(past_valid),
        .overrun(overrun), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pat(input int a);
        return 8'(a) ^ 8'hA5 ^ 8'(a >> 8);
    endfunction

    // Single-port SRAM with a programmable number of wait states.
    assign mem_ack   = mem_req && ack_en && (wcnt >= wait_n);
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (rst) wcnt <= 0;
        else if (mem_req && !mem_ack) wcnt <= wcnt + 1;
        else wcnt <= 0;
        if (clr) for (int i = 0; i < DEPTH; i++) mem[i] <= pat(i);
        else if (mem_req && mem_ack) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            log_q.push_back({mem_we, mem_addr, mem_we ? mem_wdata : mem_rdata});
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; clr = 1'b1; sample_valid = 1'b0; search = 1'b0;
        @(negedge clk);
        rst = 1'b0; clr = 1'b0;
    endtask

    task automatic write_chk(input logic [7:0] d, input logic [12:0] addr);
        @(negedge clk);
        sample_valid = 1'b1; save_audio = d;
        @(negedge clk);
        sample_valid = 1'b0;
        chk("wr_req", mem_req, 1);
        chk("wr_we", mem_we, 1);
        chk("wr_addr", mem_addr, addr);
        chk("wr_wdata", mem_wdata, d);
        @(negedge clk);
        chk("wr_req_drop", mem_req, 0);
    endtask

    task automatic search_chk(input logic [12:0] off, input logic exp_req, input logic [12:0] addr, input logic [7:0] d);
        @(negedge clk);
        search = 1'b1; offset = off;
        @(negedge clk);
        search = 1'b0;
        chk("rd_req", mem_req, exp_req);
        if (exp_req) begin
            chk("rd_we", mem_we, 0);
            chk("rd_addr", mem_addr, addr);
        end
        @(negedge clk);
        chk("rd_pv", past_valid, 1);
        chk("rd_data", past_output, d);
        @(negedge clk);
        chk("rd_pv_pulse", past_valid, 0);
    endtask

    initial begin
        int base, n, kind, idx;
        logic [7:0] d, got, exp;
        logic [12:0] o;
        logic got_pv, done;
        repeat (2) @(negedge clk);
        chk("rst_past_output", past_output, 0);
        chk("rst_past_valid", past_valid, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_mem_req", mem_req, 0);
        rst = 1'b0; clr = 1'b0;

        // Reset asserted in the middle of a stalled write, with overrun already raised.
        ack_en = 1'b0;
        @(negedge clk); sample_valid = 1'b1; save_audio = 8'h77;
        @(negedge clk); sample_valid = 1'b0;
        chk("midwr_req", mem_req, 1);
        @(negedge clk); sample_valid = 1'b1; save_audio = 8'h78;
        @(negedge clk); sample_valid = 1'b0;
        chk("midwr_overrun", overrun, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_mem_req", mem_req, 0);
        chk("async_overrun", overrun, 0);
        chk("async_past_valid", past_valid, 0);
        @(negedge clk); rst = 1'b0; ack_en = 1'b1;

        write_chk(8'h11, 13'd0);
        write_chk(8'h22, 13'd1);
        write_chk(8'h33, 13'd2);

        tbl[0] = '{13'd1, 1'b1, 13'd2, 8'h33};
        tbl[1] = '{13'd2, 1'b1, 13'd1, 8'h22};
        tbl[2] = '{13'd3, 1'b1, 13'd0, 8'h11};
        tbl[3] = '{13'd5, !ZF, 13'd8190, ZF ? 8'h00 : pat(8190)};
        tbl[4] = '{13'd0, !ZF, 13'd3, ZF ? 8'h00 : pat(3)};
        for (int i = 0; i < 5; i++) search_chk(tbl[i].off, tbl[i].exp_req, tbl[i].exp_addr, tbl[i].exp_data);

        // Write and search together behind a 3-cycle memory stall; a second sample is lost.
        wait_n = 3;
        base = log_q.size();
        @(negedge clk); sample_valid = 1'b1; save_audio = 8'h44; search = 1'b1; offset = 13'd1;
        @(negedge clk); sample_valid = 1'b0; search = 1'b0;
        @(negedge clk); sample_valid = 1'b1; save_audio = 8'h55;
        @(negedge clk); sample_valid = 1'b0;
        got_pv = 1'b0;
        for (int c = 0; c < 40 && !got_pv; c++) begin
            @(negedge clk);
            if (past_valid) begin got_pv = 1'b1; got = past_output; end
        end
        chk("sim_pv_timeout", got_pv, 1);
        chk("sim_data", got, 8'h44);
        chk("sim_overrun", overrun, 1);
        chk("sim_txn_count", log_q.size() - base, 2);
        if (log_q.size() >= base + 2) begin
            chk("sim_first_write", {log_q[base].we, log_q[base].addr, log_q[base].data}, {1'b1, 13'd3, 8'h44});
            chk("sim_then_read", {log_q[base+1].we, log_q[base+1].addr}, {1'b0, 13'd3});
        end
        wait_n = 0;

        // Randomized traffic against a sample-history model.
        do_reset();
        hist.delete();
        n = 0;
        for (int s = 0; s < 250; s++) begin
            kind = $urandom_range(0, 2);
            wait_n = $urandom_range(0, 2);
            d = 8'($urandom);
            o = ($urandom_range(0, 3) == 0) ? 13'($urandom) : 13'($urandom_range(0, n + 2));
            base = log_q.size();
            @(negedge clk);
            sample_valid = (kind != 1); save_audio = d;
            search = (kind != 0); offset = o;
            @(negedge clk);
            sample_valid = 1'b0; search = 1'b0;
            got_pv = 1'b0; done = 1'b0;
            for (int c = 0; c < 30 && !done; c++) begin
                @(negedge clk);
                if (past_valid) begin got_pv = 1'b1; got = past_output; end
                done = (kind == 1 || log_q.size() > base) && (kind == 0 || got_pv);
            end
            chk("rnd_timeout", done, 1);
            if (kind != 1) begin
                if (log_q.size() > base)
                    chk("rnd_write", {log_q[base].we, log_q[base].addr, log_q[base].data}, {1'b1, 13'(n % DEPTH), d});
                hist.push_back(d);
                n++;
            end
            if (kind != 0) begin
                idx = n - ((o == 0) ? DEPTH : int'(o));
                exp = (idx >= 0) ? hist[idx] : (ZF ? 8'h00 : pat((n - int'(o) + DEPTH) % DEPTH));
                chk("rnd_read", got, exp);
            end
        end
        chk("rnd_no_overrun", overrun, 0);
        wait_n = 0;

        // Wrap-around: fill to pointer 8191, then write the last slot.
        do_reset();
        for (int i = 0; i < DEPTH - 1; i++) begin
            @(negedge clk); sample_valid = 1'b1; save_audio = 8'(i);
            @(negedge clk); sample_valid = 1'b0;
        end
        write_chk(8'hAA, 13'd8191);
        search_chk(13'd1, 1'b1, 13'd8191, 8'hAA);
        search_chk(13'd2, 1'b1, 13'd8190, 8'hFE);
        search_chk(13'd0, 1'b1, 13'd0, 8'h00);
        chk("wrap_no_overrun", overrun, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
